// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI transaction arbiter.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LOAD,
    ST_FIRE,
    ST_WAIT_WORD,
    ST_WAIT_END,
    ST_RELEASE
  } state_t;

  localparam int WORD_LEN_DEF    = 8;
  localparam int TIMEOUT_CYC_DEF = 4096;
  localparam int CNT_W           = 5;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first active request strictly above ptr_i, wrapping.
module rr_select #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   win_o,
  output logic               any_o
);

  always_comb begin
    win_o = ptr_i;
    any_o = |req_i;
    // Walk from farthest to nearest so the nearest active requester wins.
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (req_i[(int'(ptr_i) + off) % NUM_REQ]) begin
        win_o = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI engine between NUM_REQ requesters; sequences send words, then
// receive words, with a per-word timeout.
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int WORD_LEN    = WORD_LEN_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [CNT_W*NUM_REQ-1:0] req_num_send,
  input  logic [CNT_W*NUM_REQ-1:0] req_num_rcv,
  output logic [NUM_REQ-1:0]       grant,
  input  logic [WORD_LEN-1:0]      tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic [WORD_LEN-1:0]      rx_data,
  output logic                     rx_valid,
  output logic                     txn_done,
  output logic                     txn_err,
  output logic                     spi_process_next_word,
  output logic [WORD_LEN-1:0]      spi_data_word_send,
  output logic [CNT_W-1:0]         spi_num_word_send,
  output logic [CNT_W-1:0]         spi_num_word_rcv,
  input  logic                     spi_ready,
  input  logic                     spi_word_done,
  input  logic                     spi_transaction_done,
  input  logic [WORD_LEN-1:0]      spi_data_word_rcv
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d, win_q, win_d, rr_win;
  logic                 any_req;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]     nsend_q, nsend_d, nrcv_q, nrcv_d;
  logic [CNT_W-1:0]     send_left_q, send_left_d, rcv_left_q, rcv_left_d;
  logic [CNT_W-1:0]     send_left_nxt, rcv_left_nxt, sel_send, sel_rcv;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [WORD_LEN-1:0]  wsend_q, wsend_d, rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d, done_q, done_d, err_q, err_d;
  logic                 in_send, tmr_tc, tmr_expired;

  rr_select #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (rr_win),
    .any_o (any_req)
  );

  assign sel_send      = req_num_send[int'(win_q)*CNT_W +: CNT_W];
  assign sel_rcv       = req_num_rcv[int'(win_q)*CNT_W +: CNT_W];
  assign in_send       = |send_left_q;
  assign send_left_nxt = in_send ? send_left_q - 1'b1 : send_left_q;
  assign rcv_left_nxt  = (!in_send && |rcv_left_q) ? rcv_left_q - 1'b1 : rcv_left_q;
  // Compare one short so the error strobe lands TIMEOUT_CYC cycles after the trigger.
  assign tmr_tc        = (tmr_q == TMR_W'(TIMEOUT_CYC - 2));
  assign tmr_expired   = tmr_tc &&
                         ((state_q == ST_WAIT_WORD && !spi_word_done) ||
                          (state_q == ST_WAIT_END  && !spi_transaction_done));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (any_req) state_d = ST_GRANT;
      ST_GRANT: begin
        if (sel_send != '0)     state_d = ST_LOAD;
        else if (sel_rcv != '0) state_d = ST_FIRE;
        else                    state_d = ST_RELEASE;
      end
      ST_LOAD:      if (tx_valid) state_d = ST_FIRE;
      ST_FIRE:      if (spi_ready) state_d = ST_WAIT_WORD;
      ST_WAIT_WORD: begin
        if (spi_word_done) begin
          if (send_left_nxt != '0)     state_d = ST_LOAD;
          else if (rcv_left_nxt != '0) state_d = ST_FIRE;
          else                         state_d = ST_WAIT_END;
        end else if (tmr_tc) begin
          state_d = ST_RELEASE;
        end
      end
      ST_WAIT_END:  if (spi_transaction_done || tmr_tc) state_d = ST_RELEASE;
      ST_RELEASE:   state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_ready              = (state_q == ST_LOAD);
    spi_process_next_word = (state_q == ST_FIRE) && spi_ready;
  end

  always_comb begin
    ptr_d       = ptr_q;
    win_d       = win_q;
    grant_d     = grant_q;
    nsend_d     = nsend_q;
    nrcv_d      = nrcv_q;
    send_left_d = send_left_q;
    rcv_left_d  = rcv_left_q;
    tmr_d       = '0;
    wsend_d     = wsend_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = tmr_expired;
    if (state_q == ST_IDLE && any_req) begin
      win_d           = rr_win;
      grant_d         = '0;
      grant_d[rr_win] = 1'b1;
    end
    if (state_q == ST_GRANT) begin
      nsend_d     = sel_send;
      nrcv_d      = sel_rcv;
      send_left_d = sel_send;
      rcv_left_d  = sel_rcv;
    end
    if (state_q == ST_LOAD && tx_valid) wsend_d = tx_data;
    if (state_q == ST_WAIT_WORD || state_q == ST_WAIT_END) tmr_d = tmr_q + 1'b1;
    if (state_q == ST_WAIT_WORD && spi_word_done) begin
      send_left_d = send_left_nxt;
      rcv_left_d  = rcv_left_nxt;
      if (!in_send) begin
        rx_valid_d = 1'b1;
        rx_data_d  = spi_data_word_rcv;
      end
    end
    if (state_d == ST_RELEASE) begin
      grant_d = '0;
      done_d  = !tmr_expired;
    end
    if (state_q == ST_RELEASE) ptr_d = win_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      win_q       <= '0;
      grant_q     <= '0;
      nsend_q     <= '0;
      nrcv_q      <= '0;
      send_left_q <= '0;
      rcv_left_q  <= '0;
      tmr_q       <= '0;
      wsend_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      grant_q     <= grant_d;
      nsend_q     <= nsend_d;
      nrcv_q      <= nrcv_d;
      send_left_q <= send_left_d;
      rcv_left_q  <= rcv_left_d;
      tmr_q       <= tmr_d;
      wsend_q     <= wsend_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign grant              = grant_q;
  assign spi_num_word_send  = nsend_q;
  assign spi_num_word_rcv   = nrcv_q;
  assign spi_data_word_send = wsend_q;
  assign rx_data            = rx_data_q;
  assign rx_valid           = rx_valid_q;
  assign txn_done           = done_q;
  assign txn_err            = err_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a small SPI engine model.
module tb_spi_txn_arbiter;

  localparam int NR = 2;
  localparam int WL = 8;
  localparam int TO = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [5*NR-1:0] req_num_send, req_num_rcv;
  logic [NR-1:0]   grant;
  logic [WL-1:0]   tx_data;
  logic            tx_valid, tx_ready;
  logic [WL-1:0]   rx_data;
  logic            rx_valid, txn_done, txn_err;
  logic            spi_process_next_word;
  logic [WL-1:0]   spi_data_word_send;
  logic [4:0]      spi_num_word_send, spi_num_word_rcv;
  logic            spi_ready, spi_word_done, spi_transaction_done;
  logic [WL-1:0]   spi_data_word_rcv;

  spi_txn_arbiter #(.NUM_REQ(NR), .WORD_LEN(WL), .TIMEOUT_CYC(TO)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .req                   (req),
    .req_num_send          (req_num_send),
    .req_num_rcv           (req_num_rcv),
    .grant                 (grant),
    .tx_data               (tx_data),
    .tx_valid              (tx_valid),
    .tx_ready              (tx_ready),
    .rx_data               (rx_data),
    .rx_valid              (rx_valid),
    .txn_done              (txn_done),
    .txn_err               (txn_err),
    .spi_process_next_word (spi_process_next_word),
    .spi_data_word_send    (spi_data_word_send),
    .spi_num_word_send     (spi_num_word_send),
    .spi_num_word_rcv      (spi_num_word_rcv),
    .spi_ready             (spi_ready),
    .spi_word_done         (spi_word_done),
    .spi_transaction_done  (spi_transaction_done),
    .spi_data_word_rcv     (spi_data_word_rcv)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int ncyc = 0, dly = 0, pnw_cnt = 0, done_cnt = 0, err_cnt = 0;
  int fire_cyc = 0, err_cyc = 0;
  logic td_next = 1'b0;
  logic eng_en = 1'b1;
  logic [WL-1:0] eng_rx = '0;
  logic [NR-1:0] grant_at_err = '1;
  logic [WL-1:0] sent_q[$];
  logic [WL-1:0] rx_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin nstep(); n++; end
    chk(tag, 32'(n < 200), 1);
  endtask

  task automatic send_word(input logic [WL-1:0] d);
    wait_ready("tx_ready_wait");
    tx_data  = d;
    tx_valid = 1'b1;
    nstep();
    tx_valid = 1'b0;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (grant == '0 && n < 100) begin nstep(); n++; end
    chk(tag, 32'(n < 100), 1);
  endtask

  task automatic wait_txn(input string tag);
    int base = done_cnt + err_cnt;
    int n = 0;
    while (done_cnt + err_cnt == base && n < 400) begin nstep(); n++; end
    chk(tag, 32'(n < 400), 1);
  endtask

  // Engine model and monitor, both on the falling edge.
  initial begin
    spi_word_done        = 1'b0;
    spi_transaction_done = 1'b0;
    spi_data_word_rcv    = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        dly = 0; td_next = 1'b0;
        spi_word_done = 1'b0; spi_transaction_done = 1'b0;
      end else begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (txn_done) done_cnt++;
        if (txn_err) begin err_cnt++; err_cyc = ncyc; grant_at_err = grant; end
        spi_word_done        = 1'b0;
        spi_transaction_done = td_next;
        td_next              = 1'b0;
        if (dly > 0) begin
          dly--;
          if (dly == 0) begin
            spi_word_done     = 1'b1;
            spi_data_word_rcv = eng_rx;
            td_next           = 1'b1;
          end
        end
        if (spi_process_next_word) begin
          pnw_cnt++;
          fire_cyc = ncyc;
          sent_q.push_back(spi_data_word_send);
          if (eng_en) dly = 2;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_pnw, b_done, b_err, b_rx, b_sent, w, g, n;
    rst = 1'b1; req = '0; req_num_send = '0; req_num_rcv = '0;
    tx_data = '0; tx_valid = 1'b0; spi_ready = 1'b1;
    nstep(); nstep();
    chk("rst_grant", grant, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_done", txn_done, 0);
    chk("rst_err", txn_err, 0);
    chk("rst_pnw", spi_process_next_word, 0);
    chk("rst_word_send", spi_data_word_send, 0);
    chk("rst_num_send", spi_num_word_send, 0);
    rst = 1'b0;
    nstep();

    // send=2 rcv=1 transaction
    req_num_send[4:0] = 5'd2; req_num_rcv[4:0] = 5'd1; eng_rx = 8'h5A; req = 2'b01;
    b_pnw = pnw_cnt; b_done = done_cnt; b_err = err_cnt; b_rx = rx_q.size(); b_sent = sent_q.size();
    send_word(8'hA5);
    chk("t1_grant", grant, 2'b01);
    chk("t1_num_send", spi_num_word_send, 2);
    chk("t1_num_rcv", spi_num_word_rcv, 1);
    req = '0;
    send_word(8'h3C);
    wait_txn("t1_end");
    nstep(); nstep();
    chk("t1_pnw_count", pnw_cnt - b_pnw, 3);
    chk("t1_word0", sent_q[b_sent], 8'hA5);
    chk("t1_word1", sent_q[b_sent+1], 8'h3C);
    chk("t1_rx_count", rx_q.size() - b_rx, 1);
    chk("t1_rx_data", rx_q[b_rx], 8'h5A);
    chk("t1_done", done_cnt - b_done, 1);
    chk("t1_err", err_cnt - b_err, 0);
    chk("t1_grant_free", grant, 0);

    // timeout: engine never finishes the word
    eng_en = 1'b0; req_num_send[4:0] = 5'd0; req_num_rcv[4:0] = 5'd1; req = 2'b01;
    b_pnw = pnw_cnt; b_done = done_cnt; b_err = err_cnt; b_rx = rx_q.size();
    wait_grant("to_grant_wait");
    req = '0;
    wait_txn("to_end");
    nstep(); nstep();
    chk("to_err", err_cnt - b_err, 1);
    chk("to_done", done_cnt - b_done, 0);
    chk("to_latency", err_cyc - fire_cyc, TO);
    chk("to_grant_at_err", grant_at_err, 0);
    chk("to_no_rx", rx_q.size() - b_rx, 0);
    chk("to_pnw", pnw_cnt - b_pnw, 1);
    eng_en = 1'b1;

    // tx_valid stalled 50 cycles in LOAD
    req_num_send[4:0] = 5'd1; req_num_rcv[4:0] = 5'd0; req = 2'b01;
    b_pnw = pnw_cnt; b_done = done_cnt; b_err = err_cnt; b_sent = sent_q.size();
    wait_ready("stall_ready_wait");
    req = '0;
    repeat (50) nstep();
    chk("stall_tx_ready", tx_ready, 1);
    chk("stall_no_pnw", pnw_cnt - b_pnw, 0);
    chk("stall_no_err", err_cnt - b_err, 0);
    send_word(8'h99);
    wait_txn("stall_end");
    nstep(); nstep();
    chk("stall_word", sent_q[b_sent], 8'h99);
    chk("stall_done", done_cnt - b_done, 1);
    chk("stall_err", err_cnt - b_err, 0);

    // reset in WAIT_WORD
    eng_en = 1'b0; req_num_send[4:0] = 5'd0; req_num_rcv[4:0] = 5'd1; req = 2'b01;
    b_pnw = pnw_cnt; b_done = done_cnt; b_err = err_cnt;
    wait_grant("mr_grant_wait");
    req = '0;
    n = 0;
    while (pnw_cnt == b_pnw && n < 50) begin nstep(); n++; end
    chk("mr_fire_wait", 32'(n < 50), 1);
    nstep(); nstep(); nstep();
    rst = 1'b1;
    #1;
    chk("mr_grant", grant, 0);
    chk("mr_tx_ready", tx_ready, 0);
    chk("mr_pnw", spi_process_next_word, 0);
    nstep(); nstep();
    rst = 1'b0;
    nstep();
    chk("mr_no_done", done_cnt - b_done, 0);
    chk("mr_no_err", err_cnt - b_err, 0);
    eng_en = 1'b1; req_num_send[4:0] = 5'd1; req_num_rcv[4:0] = 5'd1; eng_rx = 8'hC3; req = 2'b01;
    b_done = done_cnt; b_err = err_cnt; b_rx = rx_q.size(); b_sent = sent_q.size();
    send_word(8'h77);
    chk("mr_regrant", grant, 2'b01);
    req = '0;
    wait_txn("mr_end");
    nstep(); nstep();
    chk("mr_word", sent_q[b_sent], 8'h77);
    chk("mr_rx", rx_q[b_rx], 8'hC3);
    chk("mr_done", done_cnt - b_done, 1);
    chk("mr_err", err_cnt - b_err, 0);

    // round-robin with empty transactions after reset
    rst = 1'b1; nstep(); nstep(); rst = 1'b0; nstep();
    req_num_send = '0; req_num_rcv = '0;
    b_pnw = pnw_cnt; b_done = done_cnt; b_err = err_cnt;
    for (int pass = 0; pass < 2; pass++) begin
      req = 2'b11;
      wait_grant("rr_grant_wait");
      chk("rr_first", grant, 2'b01);
      req[0] = 1'b0;
      w = 0;
      while (grant != '0 && w < 20) begin w++; nstep(); end
      g = 0;
      while (grant == '0 && g < 20) begin g++; nstep(); end
      chk("rr_width", w, 1);
      chk("rr_gap", g, 2);
      chk("rr_second", grant, 2'b10);
      req[1] = 1'b0;
      nstep(); nstep(); nstep();
    end
    chk("rr_done", done_cnt - b_done, 4);
    chk("rr_no_pnw", pnw_cnt - b_pnw, 0);
    chk("rr_no_err", err_cnt - b_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
